moore_seq_detector_param: RTL and testbench



---
 rtl/moore_seq_detector_param.sv | 140 ++++++++++++++
 tb/tb_moore_seq_detector_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial sequence detector.
// Detects a SEQ_LEN-bit runtime-loadable pattern on a qualified 1-bit stream, with
// runtime-selectable overlapping / non-overlapping detection and a saturating match counter.
// Optional sticky match flag enabled by defining SEQ_DET_STICKY_EN.
module moore_seq_detector_param #(
  parameter int unsigned          SEQ_LEN  = 3,
  parameter logic [SEQ_LEN-1:0]   SEQ_INIT = 3'b101,
  parameter int unsigned          CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_in,
  input  logic               in_valid,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [SEQ_LEN-1:0] cfg_pattern,
  output logic               data_out,
  output logic [CNT_W-1:0]   match_count,
  output logic               match_sticky,
  input  logic               clr_sticky
);

  localparam int unsigned SW = $clog2(SEQ_LEN + 1);
  localparam logic [SW-1:0] StMatch = SW'(SEQ_LEN);

  logic [SW-1:0]      state_q, state_d;
  logic [SEQ_LEN-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               enter_match;

  // Single bit of a pattern by position; shifting avoids a variable-width bit select.
  function automatic logic pat_bit(input logic [SEQ_LEN-1:0] p, input int idx);
    logic [SEQ_LEN-1:0] t;
    t = p >> idx;
    return t[0];
  endfunction

  // Longest suffix of (first k pattern bits + b) that is also a pattern prefix, capped at
  // SEQ_LEN. Pattern position n (0 = first received) lives at bit SEQ_LEN-1-n.
  // For k < SEQ_LEN this also covers the direct-match case (j = k+1).
  function automatic logic [SW-1:0] fallback(input logic [SEQ_LEN-1:0] p,
                                             input logic [SW-1:0]      k_in,
                                             input logic               b);
    int   k;
    int   best;
    logic ok;
    k    = int'(k_in);
    best = 0;
    for (int j = 1; j <= int'(SEQ_LEN); j++) begin
      if (j <= k + 1) begin
        ok = (pat_bit(p, int'(SEQ_LEN) - j) == b);
        for (int i = 0; i < int'(SEQ_LEN) - 1; i++) begin
          if (i < j - 1) begin
            if (pat_bit(p, int'(SEQ_LEN) - 1 - i) !=
                pat_bit(p, int'(SEQ_LEN) - 1 - (k + 1 - j + i))) begin
              ok = 1'b0;
            end
          end
        end
        if (ok) best = j;
      end
    end
    return SW'(best);
  endfunction

  // State, pattern and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      pat_q   <= SEQ_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a load wins over data and drops the sampled bit; otherwise KMP step.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    enter_match = 1'b0;
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      state_d = '0;
    end else if (in_valid) begin
      if (state_q == StMatch && !overlap) begin
        state_d = (data_in == pat_q[SEQ_LEN-1]) ? SW'(1) : '0;
      end else begin
        state_d = fallback(pat_q, state_q, data_in);
      end
      enter_match = (state_d == StMatch);
    end
  end

  // Saturating match counter.
  always_comb begin
    cnt_d = cnt_q;
    if (enter_match && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Moore outputs decoded from registers only.
  always_comb begin
    data_out    = (state_q == StMatch);
    match_count = cnt_q;
  end

`ifdef SEQ_DET_STICKY_EN
  logic sticky_q, sticky_d;

  // Sticky flag: a set on the same edge as a clear wins.
  always_comb begin
    sticky_d = sticky_q;
    if (enter_match) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign match_sticky = sticky_q;
`else
  logic unused_clr_sticky;
  assign unused_clr_sticky = clr_sticky;
  assign match_sticky      = 1'b0;
`endif

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Self-checking bench for moore_seq_detector_param. A history-based reference model pushes
// expected outputs to a scoreboard queue as each cycle is driven; they are popped and
// compared one cycle later. A second instance with CNT_W=2 checks early saturation.
module tb_moore_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in, in_valid, overlap, cfg_load, clr_sticky;
  logic [2:0] cfg_pattern;
  logic       data_out, data_out2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic       match_sticky, match_sticky2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       d;
    logic [7:0] c8;
    logic [1:0] c2;
    logic       st;
  } exp_t;
  exp_t sb[$];

  // Reference model: bits since last restart; match iff history ends with the pattern.
  logic [2:0]  m_pat;
  logic [15:0] m_hist;
  int          m_hlen;
  logic        m_match;
  int          m_c8, m_c2;
  logic        m_st;

  always #5 clk = ~clk;

  moore_seq_detector_param #(.SEQ_LEN(3), .SEQ_INIT(3'b101), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .data_out(data_out),
    .match_count(match_count), .match_sticky(match_sticky), .clr_sticky(clr_sticky)
  );

  moore_seq_detector_param #(.SEQ_LEN(3), .SEQ_INIT(3'b101), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .overlap(overlap),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .data_out(data_out2),
    .match_count(match_count2), .match_sticky(match_sticky2), .clr_sticky(clr_sticky)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat   = 3'b101;
    m_hist  = '0;
    m_hlen  = 0;
    m_match = 1'b0;
    m_c8    = 0;
    m_c2    = 0;
    m_st    = 1'b0;
  endtask

  // Drive one cycle, predict, then compare after the edge.
  task automatic step(input logic v, input logic b, input logic ov, input logic ld,
                      input logic [2:0] np, input logic clr);
    logic enter;
    exp_t e, o;
    in_valid    = v;
    data_in     = b;
    overlap     = ov;
    cfg_load    = ld;
    cfg_pattern = np;
    clr_sticky  = clr;
    enter = 1'b0;
    if (ld) begin
      m_pat   = np;
      m_hlen  = 0;
      m_match = 1'b0;
    end else if (v) begin
      if (m_match && !ov) m_hlen = 0;
      m_hist = {m_hist[14:0], b};
      if (m_hlen < 16) m_hlen++;
      m_match = (m_hlen >= 3) && (m_hist[2:0] == m_pat);
      enter   = m_match;
    end
    if (enter) begin
      if (m_c8 < 255) m_c8++;
      if (m_c2 < 3) m_c2++;
      m_st = 1'b1;
    end else if (clr) begin
      m_st = 1'b0;
    end
    e.d  = m_match;
    e.c8 = 8'(m_c8);
    e.c2 = 2'(m_c2);
`ifdef SEQ_DET_STICKY_EN
    e.st = m_st;
`else
    e.st = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      o = sb.pop_front();
      check_eq("data_out", 32'(data_out), 32'(o.d));
      check_eq("match_count", 32'(match_count), 32'(o.c8));
      check_eq("data_out_c2", 32'(data_out2), 32'(o.d));
      check_eq("match_count_c2", 32'(match_count2), 32'(o.c2));
      check_eq("match_sticky", 32'(match_sticky), 32'(o.st));
    end
  endtask

  task automatic bit_in(input logic b, input logic ov);
    step(1'b1, b, ov, 1'b0, 3'b000, 1'b0);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    in_valid = 1'b0;
    cfg_load = 1'b0;
    rst = 1'b1;
    #1;
    check_eq({tag, "_data_out"}, 32'(data_out), 32'd0);
    check_eq({tag, "_count"}, 32'(match_count), 32'd0);
    check_eq({tag, "_count_c2"}, 32'(match_count2), 32'd0);
    check_eq({tag, "_sticky"}, 32'(match_sticky), 32'd0);
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    data_in = 1'b0; in_valid = 1'b0; overlap = 1'b1; cfg_load = 1'b0;
    cfg_pattern = 3'b000; clr_sticky = 1'b0;
    model_reset();
    #2;
    check_eq("rst_data_out", 32'(data_out), 32'd0);
    check_eq("rst_count", 32'(match_count), 32'd0);
    check_eq("rst_sticky", 32'(match_sticky), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Overlapping 1,0,1,0,1: two matches.
    bit_in(1, 1); bit_in(0, 1); bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
    check_eq("t1_count", 32'(match_count), 32'd2);
    async_reset("r1");

    // Non-overlapping: one match.
    bit_in(1, 0); bit_in(0, 0); bit_in(1, 0); bit_in(0, 0); bit_in(1, 0);
    check_eq("t2_count", 32'(match_count), 32'd1);
    async_reset("r2");

    // 1,1,0,1: fallback to S1 on the second 1.
    bit_in(1, 1); bit_in(1, 1); bit_in(0, 1); bit_in(1, 1);
    async_reset("r3");

    // Load 110 while in S2; loaded-edge bit discarded.
    bit_in(1, 1); bit_in(0, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 3'b110, 1'b0);
    bit_in(1, 1); bit_in(1, 1); bit_in(0, 1);
    bit_in(1, 1); bit_in(1, 1); bit_in(0, 1);
    async_reset("r4");

    // Qualified input with gaps; output held through an invalid cycle.
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    async_reset("r5");

    // Five overlapping matches; sticky clear, and set-beats-clear on the same edge.
    bit_in(1, 1);
    for (int i = 0; i < 5; i++) begin
      bit_in(0, 1);
      bit_in(1, 1);
    end
    check_eq("t6_count_c2_sat", 32'(match_count2), 32'd3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
    // Reset while in MATCH.
    bit_in(0, 1); bit_in(1, 1);
    async_reset("r6");

    // Drive the 8-bit counter to saturation.
    bit_in(1, 1);
    for (int i = 0; i < 260; i++) begin
      bit_in(0, 1);
      bit_in(1, 1);
    end
    check_eq("t7_count_sat", 32'(match_count), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
